// File: rtl/mcore_memreq_initiator_pkg.sv
// Shared encodings and control-word layout helpers for the mcore memreq initiator.
// Request control is {type, opaque, addr, len}; response control is {type, opaque, len}.
package mcore_memreq_initiator_pkg;

    localparam int TYPE_NBITS = 3;

    typedef enum logic [2:0] {
        MT_READ       = 3'd0,
        MT_WRITE      = 3'd1,
        MT_WRITE_INIT = 3'd2,
        MT_AMO_ADD    = 3'd3,
        MT_AMO_AND    = 3'd4,
        MT_AMO_OR     = 3'd5
    } msg_type_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_IDLE  = 2'd2
    } state_t;

    function automatic int len_nbits(input int d);
        return $clog2(d / 8);
    endfunction

    function automatic int req_ctrl_nbits(input int o, input int a, input int d);
        return TYPE_NBITS + o + a + len_nbits(d);
    endfunction

    function automatic int resp_ctrl_nbits(input int o, input int d);
        return TYPE_NBITS + o + len_nbits(d);
    endfunction

    // Field offsets, counted from bit 0 where len sits.
    function automatic int req_opq_off(input int a, input int d);
        return len_nbits(d) + a;
    endfunction

    function automatic int req_type_off(input int o, input int a, input int d);
        return len_nbits(d) + a + o;
    endfunction

    function automatic int resp_opq_off(input int d);
        return len_nbits(d);
    endfunction

    function automatic int resp_type_off(input int o, input int d);
        return len_nbits(d) + o;
    endfunction

endpackage

// File: rtl/mcore_memreq_tag_fifo.sv
// In-order FIFO of expected {tag, type} entries for in-flight requests.
// Push and pop may happen in the same cycle, including when full.
module mcore_memreq_tag_fifo #(
    parameter int p_depth = 4,
    parameter int p_width = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [p_width-1:0] wdata,
    input  logic               pop,
    output logic [p_width-1:0] rdata,
    output logic               full,
    output logic               empty
);

    localparam int AW = (p_depth > 1) ? $clog2(p_depth) : 1;
    localparam logic [AW-1:0] LAST = AW'(p_depth - 1);
    localparam logic [AW:0] DEPTH = (AW + 1)'(p_depth);

    logic [p_width-1:0] mem [p_depth];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0] count;
    logic do_push;
    logic do_pop;

    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= (wptr == LAST) ? '0 : wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= (rptr == LAST) ? '0 : rptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW + 1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/mcore_memreq_initiator.sv
// Initiator end of the split control/data memreq protocol: tags client commands,
// tracks them in order and checks responses. Optional: MCORE_MEMREQ_INIT_CHECK_EN.
module mcore_memreq_initiator
    import mcore_memreq_initiator_pkg::*;
#(
    parameter int p_opaque_nbits    = 8,
    parameter int p_addr_nbits      = 32,
    parameter int p_data_nbits      = 32,
    parameter int p_max_outstanding = 4,
    localparam int LEN_W  = len_nbits(p_data_nbits),
    localparam int REQ_W  = req_ctrl_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits),
    localparam int RESP_W = resp_ctrl_nbits(p_opaque_nbits, p_data_nbits),
    localparam int CNT_W  = $clog2(p_max_outstanding) + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req_level,
    input  logic                    sec_level,
    input  logic                    drain,
    output logic                    drain_done,
    input  logic                    cmd_val,
    output logic                    cmd_rdy,
    input  logic [2:0]              cmd_type,
    input  logic [p_addr_nbits-1:0] cmd_addr,
    input  logic [LEN_W-1:0]        cmd_len,
    input  logic [p_data_nbits-1:0] cmd_data,
    output logic                    memreq_val,
    input  logic                    memreq_rdy,
    output logic [REQ_W-1:0]        memreq_control,
    output logic [p_data_nbits-1:0] memreq_data,
    input  logic                    memresp_val,
    output logic                    memresp_rdy,
    input  logic [RESP_W-1:0]       memresp_control,
    input  logic [p_data_nbits-1:0] memresp_data,
    output logic                    rsp_val,
    input  logic                    rsp_rdy,
    output logic [2:0]              rsp_type,
    output logic [p_data_nbits-1:0] rsp_data,
    output logic                    rsp_err,
    output logic [CNT_W-1:0]        inflight
);

    // Every channel is valid/ready: a transfer happens on a clock edge where both are high,
    // and a producer holds valid and its payload stable until that edge.
    localparam int FIFO_W        = p_opaque_nbits + TYPE_NBITS;
    localparam int REQ_OPQ_OFF   = req_opq_off(p_addr_nbits, p_data_nbits);
    localparam int REQ_TYPE_OFF  = req_type_off(p_opaque_nbits, p_addr_nbits, p_data_nbits);
    localparam int RESP_OPQ_OFF  = resp_opq_off(p_data_nbits);
    localparam int RESP_TYPE_OFF = resp_type_off(p_opaque_nbits, p_data_nbits);
    localparam logic [CNT_W:0] MAX_OUT = (CNT_W + 1)'(p_max_outstanding);

    state_t state;
    logic [p_opaque_nbits-1:0] tag;
    logic [p_opaque_nbits-1:0] tag_next;
    logic [p_opaque_nbits-1:0] head_tag;
    logic [p_opaque_nbits-1:0] resp_opq;
    logic [TYPE_NBITS-1:0] head_type;
    logic [TYPE_NBITS-1:0] resp_type;
    logic [FIFO_W-1:0] head;
    logic [FIFO_W-1:0] push_entry;
    logic [CNT_W:0] occupancy;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_pop;
    logic cmd_fire;
    logic req_fire;
    logic resp_fire;
    logic err_now;
    logic unused;

    assign req_fire    = memreq_val && memreq_rdy;
    assign resp_fire   = memresp_val && memresp_rdy;
    assign cmd_fire    = cmd_val && cmd_rdy;
    assign occupancy   = {1'b0, inflight} + {{CNT_W{1'b0}}, memreq_val};
    assign cmd_rdy     = (state == ST_RUN) && (occupancy < MAX_OUT) && (!memreq_val || memreq_rdy);
    assign memresp_rdy = !rsp_val || rsp_rdy;
    assign drain_done  = (state == ST_IDLE) && drain;
    assign fifo_pop    = resp_fire && !fifo_empty;

    // A command accepted while the stage drains must take the tag after the departing one.
    assign tag_next   = req_fire ? tag + p_opaque_nbits'(1) : tag;
    assign push_entry = {memreq_control[REQ_OPQ_OFF +: p_opaque_nbits],
                         memreq_control[REQ_TYPE_OFF +: TYPE_NBITS]};
    assign head_tag   = head[TYPE_NBITS +: p_opaque_nbits];
    assign head_type  = head[TYPE_NBITS-1:0];
    assign resp_opq   = memresp_control[RESP_OPQ_OFF +: p_opaque_nbits];
    assign resp_type  = memresp_control[RESP_TYPE_OFF +: TYPE_NBITS];

`ifdef MCORE_MEMREQ_INIT_CHECK_EN
    assign err_now = fifo_empty || (resp_opq != head_tag) || (resp_type != head_type);
    assign unused  = ^{fifo_full, req_level, sec_level, memresp_control[LEN_W-1:0]};
`else
    assign err_now = 1'b0;
    assign unused  = ^{fifo_full, req_level, sec_level, memresp_control[LEN_W-1:0],
                       resp_opq, head_tag};
`endif

    mcore_memreq_tag_fifo #(
        .p_depth (p_max_outstanding),
        .p_width (FIFO_W)
    ) tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_fire),
        .wdata (push_entry),
        .pop   (fifo_pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: if (drain) state <= ST_DRAIN;
                ST_DRAIN: begin
                    if (!drain) state <= ST_RUN;
                    else if (inflight == '0 && !memreq_val) state <= ST_IDLE;
                end
                ST_IDLE: if (!drain) state <= ST_RUN;
                default: state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tag      <= '0;
            inflight <= '0;
        end else begin
            tag <= tag_next;
            if (req_fire && !fifo_pop) begin
                inflight <= inflight + CNT_W'(1);
            end else if (!req_fire && fifo_pop) begin
                inflight <= inflight - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            memreq_val     <= 1'b0;
            memreq_control <= '0;
            memreq_data    <= '0;
        end else if (cmd_fire) begin
            memreq_val     <= 1'b1;
            memreq_control <= {cmd_type, tag_next, cmd_addr, cmd_len};
            memreq_data    <= cmd_data;
        end else if (req_fire) begin
            memreq_val <= 1'b0;
        end
    end

    // A response with nothing outstanding reports its own type.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_val  <= 1'b0;
            rsp_type <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (resp_fire) begin
            rsp_val  <= 1'b1;
            rsp_type <= fifo_empty ? resp_type : head_type;
            rsp_data <= memresp_data;
            rsp_err  <= err_now;
        end else if (rsp_rdy) begin
            rsp_val <= 1'b0;
            rsp_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mcore_memreq_initiator.sv
// Directed bench for mcore_memreq_initiator: single read, back-pressure, tag wrap,
// mismatch, drain and reset mid-flight, with hand-computed expectations.
module tb_mcore_memreq_initiator;

`ifdef MCORE_MEMREQ_INIT_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        req_level;
    logic        sec_level;
    logic        drain;
    logic        drain_done;
    logic        cmd_val;
    logic        cmd_rdy;
    logic [2:0]  cmd_type;
    logic [31:0] cmd_addr;
    logic [1:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        memreq_val;
    logic        memreq_rdy;
    logic [44:0] memreq_control;
    logic [31:0] memreq_data;
    logic        memresp_val;
    logic        memresp_rdy;
    logic [12:0] memresp_control;
    logic [31:0] memresp_data;
    logic        rsp_val;
    logic        rsp_rdy;
    logic [2:0]  rsp_type;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [2:0]  inflight;

    int total = 0;
    int bad = 0;
    int fire_cnt = 0;
    logic [7:0] last_opq = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mcore_memreq_initiator dut (
        .clk             (clk),
        .reset           (reset),
        .req_level       (req_level),
        .sec_level       (sec_level),
        .drain           (drain),
        .drain_done      (drain_done),
        .cmd_val         (cmd_val),
        .cmd_rdy         (cmd_rdy),
        .cmd_type        (cmd_type),
        .cmd_addr        (cmd_addr),
        .cmd_len         (cmd_len),
        .cmd_data        (cmd_data),
        .memreq_val      (memreq_val),
        .memreq_rdy      (memreq_rdy),
        .memreq_control  (memreq_control),
        .memreq_data     (memreq_data),
        .memresp_val     (memresp_val),
        .memresp_rdy     (memresp_rdy),
        .memresp_control (memresp_control),
        .memresp_data    (memresp_data),
        .rsp_val         (rsp_val),
        .rsp_rdy         (rsp_rdy),
        .rsp_type        (rsp_type),
        .rsp_data        (rsp_data),
        .rsp_err         (rsp_err),
        .inflight        (inflight)
    );

    always @(posedge clk) begin
        if (reset && memreq_val && memreq_rdy) begin
            fire_cnt <= fire_cnt + 1;
            last_opq <= memreq_control[41:34];
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                         input int max_wait, output logic ok);
        ok = 1'b0;
        cmd_val = 1'b1;
        cmd_type = t;
        cmd_addr = a;
        cmd_len = 2'd0;
        cmd_data = d;
        for (int w = 0; w < max_wait && !ok; w++) begin
            #1;
            if (cmd_rdy) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        cmd_val = 1'b0;
    endtask

    task automatic respond(input logic [2:0] t, input logic [7:0] opq, input logic [31:0] d);
        logic ok;
        ok = 1'b0;
        memresp_val = 1'b1;
        memresp_control = {t, opq, 2'b00};
        memresp_data = d;
        for (int w = 0; w < 8 && !ok; w++) begin
            #1;
            if (memresp_rdy) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        memresp_val = 1'b0;
        check("resp_accept", 64'(ok), 64'd1);
    endtask

    initial begin
        logic ok;
        int accepted;
        int fires0;
        int wrap_bad_opq;
        int wrap_bad_err;
        logic saw_wrap_zero;
        logic [7:0] exp_tag;

        reset = 1'b0;
        req_level = 1'b0;
        sec_level = 1'b1;
        drain = 1'b0;
        cmd_val = 1'b0;
        cmd_type = 3'd0;
        cmd_addr = 32'd0;
        cmd_len = 2'd0;
        cmd_data = 32'd0;
        memreq_rdy = 1'b0;
        memresp_val = 1'b0;
        memresp_control = 13'd0;
        memresp_data = 32'd0;
        rsp_rdy = 1'b1;

        // Reset state
        repeat (3) cycle();
        check("rst_memreq_val", 64'(memreq_val), 64'd0);
        check("rst_rsp_val", 64'(rsp_val), 64'd0);
        check("rst_inflight", 64'(inflight), 64'd0);
        check("rst_drain_done", 64'(drain_done), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        reset = 1'b1;
        cycle();

        // Single read
        memreq_rdy = 1'b1;
        issue(3'd0, 32'h100, 32'h0, 1, ok);
        check("rd_cmd_accept", 64'(ok), 64'd1);
        check("rd_memreq_val", 64'(memreq_val), 64'd1);
        check("rd_memreq_control", 64'(memreq_control), 64'h400);
        cycle();
        check("rd_memreq_drop", 64'(memreq_val), 64'd0);
        check("rd_inflight", 64'(inflight), 64'd1);
        respond(3'd0, 8'h00, 32'hDEADBEEF);
        check("rd_rsp_val", 64'(rsp_val), 64'd1);
        check("rd_rsp_data", 64'(rsp_data), 64'hDEADBEEF);
        check("rd_rsp_err", 64'(rsp_err), 64'd0);
        check("rd_rsp_type", 64'(rsp_type), 64'd0);
        check("rd_inflight_done", 64'(inflight), 64'd0);
        cycle();
        check("rd_rsp_val_drop", 64'(rsp_val), 64'd0);

        // Back-pressure: tags 1..4 issue, the 5th and 6th stall
        fires0 = fire_cnt;
        accepted = 0;
        for (int i = 0; i < 6; i++) begin
            issue(3'd1, 32'h200 + 32'(i * 4), 32'(i), 4, ok);
            if (ok) accepted++;
        end
        check("bp_accepted", 64'(accepted), 64'd4);
        check("bp_fires", 64'(fire_cnt - fires0), 64'd4);
        check("bp_last_opq", 64'(last_opq), 64'd4);
        check("bp_inflight", 64'(inflight), 64'd4);
        check("bp_cmd_rdy", 64'(cmd_rdy), 64'd0);
        respond(3'd1, 8'd1, 32'h0);
        check("bp_rsp_err", 64'(rsp_err), 64'd0);
        check("bp_rsp_type", 64'(rsp_type), 64'd1);
        check("bp_inflight_3", 64'(inflight), 64'd3);
        issue(3'd1, 32'h300, 32'h55, 4, ok);
        check("bp_one_more", 64'(ok), 64'd1);
        cycle();
        check("bp_tag5", 64'(last_opq), 64'd5);
        check("bp_inflight_4", 64'(inflight), 64'd4);
        for (int i = 2; i <= 5; i++) begin
            respond(3'd1, 8'(i), 32'(i));
            check("bp_drain_err", 64'(rsp_err), 64'd0);
        end
        check("bp_inflight_0", 64'(inflight), 64'd0);

        // Tag wrap from a fresh reset: request index 256 carries opaque 0
        reset = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
        exp_tag = 8'h00;
        wrap_bad_opq = 0;
        wrap_bad_err = 0;
        saw_wrap_zero = 1'b0;
        for (int i = 0; i < 300; i++) begin
            issue(3'd0, 32'(i * 4), 32'h0, 4, ok);
            if (!ok || memreq_control[41:34] !== exp_tag) wrap_bad_opq++;
            if (i == 256 && memreq_control[41:34] === 8'h00) saw_wrap_zero = 1'b1;
            cycle();
            respond(3'd0, exp_tag, 32'(i));
            if (rsp_err !== 1'b0 || rsp_data !== 32'(i)) wrap_bad_err++;
            exp_tag = exp_tag + 8'd1;
        end
        check("wrap_opq_errors", 64'(wrap_bad_opq), 64'd0);
        check("wrap_rsp_errors", 64'(wrap_bad_err), 64'd0);
        check("wrap_req256_zero", 64'(saw_wrap_zero), 64'd1);

        // Mismatch: tags 44 and 45 in flight, answer 45 first
        issue(3'd0, 32'h40, 32'h0, 4, ok);
        cycle();
        issue(3'd0, 32'h44, 32'h0, 4, ok);
        cycle();
        check("mm_inflight_2", 64'(inflight), 64'd2);
        respond(3'd0, 8'd45, 32'h1111);
        check("mm_tag_err", 64'(rsp_err), 64'(CHK));
        check("mm_data", 64'(rsp_data), 64'h1111);
        check("mm_inflight_1", 64'(inflight), 64'd1);
        respond(3'd0, 8'd45, 32'h2222);
        check("mm_after_pop_err", 64'(rsp_err), 64'd0);
        check("mm_inflight_0", 64'(inflight), 64'd0);
        issue(3'd1, 32'h48, 32'h9, 4, ok);
        cycle();
        respond(3'd0, 8'd46, 32'h3333);
        check("mm_type_err", 64'(rsp_err), 64'(CHK));
        check("mm_head_type", 64'(rsp_type), 64'd1);

        // Drain with tags 47..49 in flight
        issue(3'd0, 32'h50, 32'h0, 4, ok);
        issue(3'd0, 32'h54, 32'h0, 4, ok);
        issue(3'd0, 32'h58, 32'h0, 4, ok);
        cycle();
        check("dr_inflight_3", 64'(inflight), 64'd3);
        drain = 1'b1;
        cycle();
        check("dr_cmd_rdy", 64'(cmd_rdy), 64'd0);
        check("dr_done_busy", 64'(drain_done), 64'd0);
        respond(3'd0, 8'd47, 32'h0);
        respond(3'd0, 8'd48, 32'h0);
        respond(3'd0, 8'd49, 32'h0);
        check("dr_done_same_cycle", 64'(drain_done), 64'd0);
        check("dr_inflight_0", 64'(inflight), 64'd0);
        cycle();
        check("dr_done", 64'(drain_done), 64'd1);
        check("dr_cmd_rdy_idle", 64'(cmd_rdy), 64'd0);
        drain = 1'b0;
        #1;
        check("dr_done_drop", 64'(drain_done), 64'd0);
        cycle();
        check("dr_cmd_rdy_back", 64'(cmd_rdy), 64'd1);

        // Reset with two in flight and a third held in the stage
        issue(3'd0, 32'h60, 32'h0, 4, ok);
        issue(3'd0, 32'h64, 32'h0, 4, ok);
        cycle();
        memreq_rdy = 1'b0;
        issue(3'd1, 32'h68, 32'h7, 4, ok);
        check("rm_stage_val", 64'(memreq_val), 64'd1);
        check("rm_inflight_2", 64'(inflight), 64'd2);
        reset = 1'b0;
        cycle();
        check("rm_inflight_0", 64'(inflight), 64'd0);
        check("rm_memreq_val", 64'(memreq_val), 64'd0);
        check("rm_rsp_val", 64'(rsp_val), 64'd0);
        reset = 1'b1;
        memreq_rdy = 1'b1;
        cycle();
        respond(3'd3, 8'd50, 32'hCAFE);
        check("rm_late_err", 64'(rsp_err), 64'(CHK));
        check("rm_late_type", 64'(rsp_type), 64'd3);
        check("rm_late_data", 64'(rsp_data), 64'hCAFE);
        check("rm_late_inflight", 64'(inflight), 64'd0);
        issue(3'd0, 32'h70, 32'h0, 4, ok);
        check("rm_tag_restart", 64'(memreq_control[41:34]), 64'd0);
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
